alu_issue: RTL

- Execute-stage issue/result sequencer sitting directly upstream and downstream of the ALU.
- Accepts decoded ops over valid/ready, selects operands, and drives the ALU's a/b/ctrl inputs from registers.
- Tracks each op through the ALU's fixed 1-cycle registered latency and captures results into an in-order result FIFO.
- Presents results to writeback over valid/ready.
- The ALU cannot stall, so back-pressure is handled by credit: an op is accepted only if a result slot is guaranteed.

---
 rtl/alu_issue.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Issue/result sequencer around a 1-cycle registered ALU, with credit-based in-order result FIFO.
// Optional performance counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue #(
    parameter int XLEN          = 32,
    parameter int ALUCTRL_WIDTH = 4,
    parameter int RES_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [ALUCTRL_WIDTH-1:0] in_op_i,
    input  logic [XLEN-1:0]          in_rs1_val_i,
    input  logic [XLEN-1:0]          in_rs2_val_i,
    input  logic [XLEN-1:0]          in_imm_i,
    input  logic                     in_use_imm_i,
    input  logic [4:0]               in_rd_i,
    output logic [XLEN-1:0]          alu_a_o,
    output logic [XLEN-1:0]          alu_b_o,
    output logic [ALUCTRL_WIDTH-1:0] aluctrl_o,
    input  logic [XLEN-1:0]          alu_out_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [XLEN-1:0]          res_data_o,
    output logic [4:0]               res_rd_o
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]              perf_issued_o,
    output logic [31:0]              perf_stall_o
`endif
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(RES_DEPTH - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(RES_DEPTH);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(RES_DEPTH);

    // S1: ALU input registers and tag of the op the ALU is sampling
    logic                     s1_v_q, s1_v_d;
    logic [4:0]               s1_rd_q, s1_rd_d;
    logic [XLEN-1:0]          alu_a_q, alu_a_d;
    logic [XLEN-1:0]          alu_b_q, alu_b_d;
    logic [ALUCTRL_WIDTH-1:0] aluctrl_q, aluctrl_d;

    // S2: op whose result is on alu_out_i
    logic                     s2_v_q, s2_v_d;
    logic [4:0]               s2_rd_q, s2_rd_d;

    // Result FIFO with a registered copy of the head entry
    logic [XLEN-1:0]          mem_data [RES_DEPTH];
    logic [4:0]               mem_rd   [RES_DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [XLEN-1:0]          head_data_q, head_data_d;
    logic [4:0]               head_rd_q, head_rd_d;

    logic                     accept;
    logic                     push;
    logic                     pop;
    logic [CW:0]              credit_used;
    logic [PW-1:0]            rd_ptr_inc;
    logic [PW-1:0]            wr_ptr_inc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign credit_used = (CW + 1)'(s1_v_q) + (CW + 1)'(s2_v_q) + (CW + 1)'(count_q);
    assign in_ready_o  = credit_used < CREDIT_MAX;
    assign res_valid_o = (count_q != '0);

    assign accept      = in_valid_i && in_ready_o;
    assign push        = s2_v_q;
    assign pop         = res_valid_o && res_ready_i;
    assign rd_ptr_inc  = ptr_inc(rd_ptr_q);
    assign wr_ptr_inc  = ptr_inc(wr_ptr_q);

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        aluctrl_d   = aluctrl_q;
        s1_rd_d     = s1_rd_q;
        s1_v_d      = accept;
        s2_v_d      = s1_v_q;
        s2_rd_d     = s1_rd_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        head_rd_d   = head_rd_q;

        if (accept) begin
            alu_a_d   = in_rs1_val_i;
            alu_b_d   = in_use_imm_i ? in_imm_i : in_rs2_val_i;
            aluctrl_d = in_op_i;
            s1_rd_d   = in_rd_i;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_inc;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_inc;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The head register must show the oldest entry right after the edge that makes it oldest.
        if (push && ((count_q == '0) || ((count_q == CW'(1)) && pop))) begin
            head_data_d = alu_out_i;
            head_rd_d   = s2_rd_q;
        end else if (pop && (count_q > CW'(1))) begin
            head_data_d = mem_data[rd_ptr_inc];
            head_rd_d   = mem_rd[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_rd_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            aluctrl_q   <= '0;
            s2_v_q      <= 1'b0;
            s2_rd_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_data_q <= '0;
            head_rd_q   <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_rd_q     <= s1_rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            aluctrl_q   <= aluctrl_d;
            s2_v_q      <= s2_v_d;
            s2_rd_q     <= s2_rd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_rd_q   <= head_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_data[wr_ptr_q] <= alu_out_i;
            mem_rd[wr_ptr_q]   <= s2_rd_q;
        end
    end

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign aluctrl_o  = aluctrl_q;
    assign res_data_o = head_data_q;
    assign res_rd_o   = head_rd_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_stall_d  = perf_stall_q;
        if (accept) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if (in_valid_i && !in_ready_o) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`endif

`ifndef SYNTHESIS
    // Credit accounting makes this unreachable; firing means the credit logic is broken.
    push_into_full_a: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == COUNT_FULL)));
`endif

endmodule
